// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage valid/ready mantissa normalizer with an
// internal leading-zero count and an exponent-clamped left shift.
module norm_shift_pipe #(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned EXP_WIDTH = 8,
  parameter  int unsigned MIN_EXP   = 1,
  localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     mant_i,
  input  logic [EXP_WIDTH-1:0] exp_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH-1:0]     mant_o,
  output logic [EXP_WIDTH-1:0] exp_o,
  output logic [CNT_WIDTH-1:0] shamt_o,
  output logic                 zero_o,
  output logic                 denorm_o
);

  localparam int unsigned MAX_W =
    (EXP_WIDTH > CNT_WIDTH) ? EXP_WIDTH : CNT_WIDTH;
  localparam int unsigned LIM_W = MAX_W + 1;

  logic                 s1_v;
  logic [WIDTH-1:0]     s1_mant;
  logic [EXP_WIDTH-1:0] s1_exp;

  logic                 s2_v;
  logic [WIDTH-1:0]     s2_mant;
  logic [EXP_WIDTH-1:0] s2_exp;
  logic [CNT_WIDTH-1:0] s2_shamt;
  logic                 s2_zero;
  logic                 s2_denorm;

  logic s2_rdy;

  assign s2_rdy  = !s2_v || ready_i;
  assign ready_o = !s1_v || s2_rdy;

  // leading-zero count: last hit wins, so the highest set bit decides
  logic [CNT_WIDTH-1:0] cnt;
  logic                 empty;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s1_mant[i]) cnt = CNT_WIDTH'(WIDTH - 1 - i);
    end
  end

  assign empty = ~|s1_mant;

  logic [LIM_W-1:0] exp_x;
  logic [LIM_W-1:0] cnt_x;
  logic [LIM_W-1:0] min_x;
  logic [LIM_W-1:0] limit;
  logic [LIM_W-1:0] shamt_x;
  logic             over;

  logic [WIDTH-1:0]     n_mant;
  logic [EXP_WIDTH-1:0] n_exp;
  logic [CNT_WIDTH-1:0] n_shamt;
  logic                 n_denorm;

  assign exp_x   = LIM_W'(s1_exp);
  assign cnt_x   = LIM_W'(cnt);
  assign min_x   = LIM_W'(MIN_EXP);
  assign limit   = (exp_x > min_x) ? exp_x - min_x : '0;
  assign over    = cnt_x > limit;
  assign shamt_x = over ? limit : cnt_x;

  // shamt never exceeds exp, so the narrow subtract cannot wrap
  assign n_mant   = empty ? '0 : s1_mant << shamt_x;
  assign n_exp    = empty ? '0 : s1_exp - EXP_WIDTH'(shamt_x);
  assign n_shamt  = empty ? '0 : CNT_WIDTH'(shamt_x);
  assign n_denorm = !empty && over;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_v      <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s2_v      <= 1'b0;
      s2_mant   <= '0;
      s2_exp    <= '0;
      s2_shamt  <= '0;
      s2_zero   <= 1'b0;
      s2_denorm <= 1'b0;
    end else if (flush_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (ready_o) begin
        s1_v <= valid_i;
        if (valid_i) begin
          s1_mant <= mant_i;
          s1_exp  <= exp_i;
        end
      end
      if (s2_rdy) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_mant   <= n_mant;
          s2_exp    <= n_exp;
          s2_shamt  <= n_shamt;
          s2_zero   <= empty;
          s2_denorm <= n_denorm;
        end
      end
    end
  end

  assign valid_o  = s2_v;
  assign mant_o   = s2_mant;
  assign exp_o    = s2_exp;
  assign shamt_o  = s2_shamt;
  assign zero_o   = s2_zero;
  assign denorm_o = s2_denorm;

  a_hold: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i && !flush_i) |=>
        (valid_o &&
         $stable({mant_o, exp_o, shamt_o, zero_o, denorm_o}))
  );

endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb_norm_shift_pipe: scoreboard bench for norm_shift_pipe
// (WIDTH=8, EXP_WIDTH=6, MIN_EXP=1).
module tb_norm_shift_pipe;

  localparam int W  = 8;
  localparam int EW = 6;
  localparam int CW = 3;

  typedef struct packed {
    logic [W-1:0]  m;
    logic [EW-1:0] e;
    logic [CW-1:0] s;
    logic          z;
    logic          d;
  } res_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  mant_i = '0;
  logic [EW-1:0] exp_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [W-1:0]  mant_o;
  logic [EW-1:0] exp_o;
  logic [CW-1:0] shamt_o;
  logic          zero_o;
  logic          denorm_o;

  int total = 0;
  int bad = 0;
  res_t q[$];
  logic accepted;

  always #5 clk_i = ~clk_i;

  norm_shift_pipe #(.WIDTH(W), .EXP_WIDTH(EW), .MIN_EXP(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .mant_i(mant_i), .exp_i(exp_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .mant_o(mant_o), .exp_o(exp_o), .shamt_o(shamt_o),
    .zero_o(zero_o), .denorm_o(denorm_o)
  );

  // reference: count leading zeros, clamp at exp-1, shift
  function automatic res_t model(input logic [W-1:0] m,
                                 input int e);
    res_t r;
    int lz, lim, sh;
    r = '0;
    if (m == 0) begin
      r.z = 1'b1;
      return r;
    end
    lz = 0;
    while (m[W-1-lz] == 1'b0) lz++;
    lim = (e > 1) ? e - 1 : 0;
    sh = (lz < lim) ? lz : lim;
    r.m = W'(int'(m) << sh);
    r.e = EW'(e - sh);
    r.s = CW'(sh);
    r.d = lz > lim;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // one clock: bookkeeping at negedge, return just after posedge
  task automatic step();
    @(negedge clk_i);
    accepted = 1'b0;
    if (!rst_ni || flush_i) q.delete();
    else if (valid_i && ready_o) begin
      q.push_back(model(mant_i, int'(exp_i)));
      accepted = 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [W-1:0] m, input logic [EW-1:0] e);
    int n;
    mant_i = m;
    exp_i = e;
    valid_i = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 50);
    valid_i = 1'b0;
    if (!accepted) chk("send_timeout", 0, 1);
  endtask

  always @(negedge clk_i) begin
    res_t a, x;
    if (rst_ni && !flush_i && valid_o && ready_i) begin
      a = '{m: mant_o, e: exp_o, s: shamt_o, z: zero_o, d: denorm_o};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %0h want none", a);
      end else begin
        x = q.pop_front();
        if (a !== x) begin
          bad++;
          $display("FAIL out_data: got m=%0h e=%0d s=%0d z=%0b d=%0b want m=%0h e=%0d s=%0d z=%0b d=%0b",
                   a.m, a.e, a.s, a.z, a.d, x.m, x.e, x.s, x.z, x.d);
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_out"}, int'({valid_o, mant_o, exp_o, shamt_o,
                            zero_o, denorm_o}), 0);
    chk({nm, "_rdy"}, int'(ready_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    step();
    step();
    chk_zero("reset");
    rst_ni = 1'b1;
    step();
    chk_zero("post_reset");

    // latency and spec examples
    ready_i = 1'b1;
    send(8'h10, 6'd20);
    chk("lat_n1", int'(valid_o), 0);
    step();
    chk("lat_n2", int'(valid_o), 1);
    chk("lat_val", int'({mant_o, exp_o, shamt_o, zero_o, denorm_o}),
        int'({8'h80, 6'd17, 3'd3, 1'b0, 1'b0}));
    send(8'h01, 6'd4);
    send(8'h00, 6'd9);
    send(8'h80, 6'd1);
    repeat (4) step();

    // stall: two ops fill the pipe, then ready_o drops
    ready_i = 1'b0;
    fork
      begin
        send(8'h03, 6'd30);
        send(8'h40, 6'd2);
        chk("stall_rdy", int'(ready_o), 0);
        chk("stall_vld", int'(valid_o), 1);
        send(8'h20, 6'd1);
        send(8'h07, 6'd63);
      end
      begin
        repeat (5) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    repeat (4) step();
    chk("stall_drain", q.size(), 0);

    // flush with both stages full
    ready_i = 1'b0;
    send(8'h11, 6'd9);
    send(8'h22, 6'd9);
    mant_i = 8'h33;
    exp_i = 6'd9;
    valid_i = 1'b1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    chk("flush_vld", int'(valid_o), 0);
    chk("flush_rdy", int'(ready_o), 1);
    ready_i = 1'b1;
    repeat (4) step();

    // reset mid-stream
    send(8'h05, 6'd12);
    send(8'h06, 6'd12);
    ready_i = 1'b0;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk_zero("mid_reset");
    ready_i = 1'b1;
    send(8'h80, 6'd0);
    repeat (3) step();
    chk("reset_drain", q.size(), 0);

    // randomized traffic with rare flush and reset
    for (int i = 0; i < 600; i++) begin
      mant_i = W'($urandom) & (8'hFF >> $urandom_range(0, 8));
      exp_i = EW'($urandom);
      valid_i = $urandom_range(0, 3) != 0;
      ready_i = $urandom_range(0, 9) < 7;
      flush_i = $urandom_range(0, 39) == 0;
      rst_ni = $urandom_range(0, 79) != 0;
      step();
    end
    flush_i = 1'b0;
    rst_ni = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (6) step();
    chk("final_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
